// File: rtl/matrix_mem_engine_if.sv
// matrix_mem_engine_if: command, status and single-port RAM signals of the matrix engine
interface matrix_mem_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              start;
    logic [1:0]        op;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W-1:0] base_c;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              done;
    modport master (
        output start, op, base_a, base_b, base_c, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, busy, done
    );
    modport slave (
        input  start, op, base_a, base_b, base_c, mem_rdata,
        output mem_addr, mem_wdata, mem_we, busy, done
    );
endinterface

// File: rtl/matrix_mem_engine.sv
// matrix_mem_engine: element-wise add/sub/transpose/negate of DIM x DIM matrices held in RAM
module matrix_mem_engine #(
    parameter int DATA_W = 16,
    parameter int DIM    = 4,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input logic                clk,
    input logic                rst,
    matrix_mem_engine_if.slave bus
);
    localparam int N  = DIM * DIM;
    localparam int KW = $clog2(N);
    localparam int CW = $clog2(DIM);
    localparam logic [1:0]    HOLD   = 2'(RD_LAT);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [CW-1:0] C_LAST = CW'(DIM - 1);
    typedef enum logic [2:0] {IDLE, RA, RB, WC, DONE} state_t;
    state_t            state_q;
    logic [1:0]        op_q, hold_q;
    logic [ADDR_W-1:0] base_a_q, base_b_q, base_c_q, mem_addr_q;
    logic [DATA_W-1:0] reg_a_q, reg_b_q, mem_wdata_q;
    logic [KW-1:0]     k_q, k_d;
    logic [CW-1:0]     row_q, col_q, row_d, col_d;
    logic              mem_we_q, busy_q, done_q;
    logic [ADDR_W-1:0] a_next_d, b_addr_d, c_addr_d;
    logic [DATA_W-1:0] res_d;
    function automatic logic [DATA_W-1:0] result(input logic [1:0] o, input logic [DATA_W-1:0] a, b);
        logic [DATA_W:0] ax, bx, s;
        ax = {a[DATA_W-1], a};
        bx = {b[DATA_W-1], b};
        s  = o == 2'b00 ? ax + bx : o == 2'b01 ? ax - bx : o == 2'b11 ? '0 - ax : ax;
        return s[DATA_W] != s[DATA_W-1] ? {s[DATA_W], {(DATA_W-1){~s[DATA_W]}}} : s[DATA_W-1:0];
    endfunction
    // The result is formed from the word arriving this cycle so it can be registered straight into WC.
    always_comb begin
        k_d      = k_q + 1'b1;
        col_d    = col_q == C_LAST ? '0 : col_q + 1'b1;
        row_d    = col_q == C_LAST ? row_q + 1'b1 : row_q;
        a_next_d = base_a_q + (op_q == 2'b10 ? ADDR_W'(col_d) * ADDR_W'(DIM) + ADDR_W'(row_d) : ADDR_W'(k_d));
        b_addr_d = base_b_q + ADDR_W'(k_q);
        c_addr_d = base_c_q + ADDR_W'(k_q);
        res_d    = result(op_q, state_q == RB ? reg_a_q : bus.mem_rdata, state_q == RB ? bus.mem_rdata : reg_b_q);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            hold_q      <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            base_c_q    <= '0;
            k_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            reg_a_q     <= '0;
            reg_b_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    op_q       <= bus.op;
                    base_a_q   <= bus.base_a;
                    base_b_q   <= bus.base_b;
                    base_c_q   <= bus.base_c;
                    k_q        <= '0;
                    row_q      <= '0;
                    col_q      <= '0;
                    hold_q     <= '0;
                    mem_addr_q <= bus.base_a;
                    busy_q     <= 1'b1;
                    state_q    <= RA;
                end
                RA: if (hold_q == HOLD) begin
                    hold_q  <= '0;
                    reg_a_q <= bus.mem_rdata;
                    if (op_q[1]) begin
                        state_q     <= WC;
                        mem_addr_q  <= c_addr_d;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= res_d;
                    end else begin
                        state_q    <= RB;
                        mem_addr_q <= b_addr_d;
                    end
                end else hold_q <= hold_q + 1'b1;
                RB: if (hold_q == HOLD) begin
                    hold_q      <= '0;
                    reg_b_q     <= bus.mem_rdata;
                    state_q     <= WC;
                    mem_addr_q  <= c_addr_d;
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= res_d;
                end else hold_q <= hold_q + 1'b1;
                WC: begin
                    mem_we_q <= 1'b0;
                    if (k_q == K_LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        k_q        <= k_d;
                        row_q      <= row_d;
                        col_q      <= col_d;
                        mem_addr_q <= a_next_d;
                        state_q    <= RA;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: doc/matrix_mem_engine.md
MATRIX_MEM_ENGINE -- requirements
Module: matrix_mem_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16: element width in bits, two's-complement signed.
REQ-002 SHALL have parameter DIM, default 4: matrix is DIM x DIM, legal range 2..8.
REQ-003 SHALL have parameter ADDR_W, default 8: RAM word-address width, one element per RAM word.
REQ-004 SHALL have parameter RD_LAT, default 1: RAM read latency in clk cycles, legal range 1..3.
REQ-005 SHALL have port clk  input  1  rising-edge system clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port start  input  1  request to run one operation, sampled only in IDLE.
REQ-008 SHALL have port op  input  2  operation: 00 add, 01 subtract (A-B), 10 transpose A, 11 negate A.
REQ-009 SHALL have ports base_a, base_b, base_c  input  ADDR_W each  base addresses of A, B and C.
REQ-010 SHALL have port mem_addr  output  ADDR_W  RAM address.
REQ-011 SHALL have port mem_wdata  output  DATA_W  RAM write data.
REQ-012 SHALL have port mem_we  output  1  RAM write enable.
REQ-013 SHALL have port mem_rdata  input  DATA_W  RAM read data.
REQ-014 SHALL have port busy  output  1  operation in progress.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL be a state machine with states IDLE, RA, RB, WC and DONE.
REQ-017 SHALL latch op and all three base addresses when start=1 in IDLE, set element index k=0, and go to RA; start outside IDLE SHALL be ignored.
REQ-018 SHALL use element k = row*DIM+col, with A/B/C element k at base+k; addresses SHALL wrap modulo 2^ADDR_W.
REQ-019 SHALL, in RA, drive mem_addr=base_a+k, or base_a+col*DIM+row for op=10, hold it for RD_LAT+1 cycles, and capture mem_rdata into reg_a on the last of those cycles.
REQ-020 SHALL, for op 00/01, then enter RB with mem_addr=base_b+k, hold it for RD_LAT+1 cycles and capture reg_b; for op 10/11 RB SHALL be skipped and base_b never driven.
REQ-021 SHALL, in WC (one cycle), drive mem_addr=base_c+k, mem_we=1 and mem_wdata=result; mem_we SHALL be 0 in every other state.
REQ-022 SHALL compute result as saturating signed arithmetic at DATA_W bits: add clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; subtract likewise; negate of minimum value yields maximum value; transpose passes reg_a.
REQ-023 SHALL, after WC, increment k and return to RA if k<DIM*DIM-1, else go to DONE.
REQ-024 SHALL take (2*RD_LAT+3) cycles per element for op 00/01 and (RD_LAT+2) cycles for op 10/11.
REQ-025 SHALL assert busy in RA, RB and WC only, and assert done for exactly the single DONE cycle, after which the block returns to IDLE.
REQ-026 SHALL ignore start during DONE; a new operation needs start in a later IDLE cycle.
REQ-027 SHALL support base_c equal to base_a (in-place) for op 00/01/11, because each element is read before it is written; in-place transpose is undefined.

Reset
REQ-028 SHALL, when rst=0 at a clk edge, go to IDLE with k=0, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, reg_a=reg_b=0, regardless of state.
REQ-029 SHALL, on reset during an operation, issue no further writes; elements already written remain, and no done pulse is produced.
REQ-030 SHALL have rst override start in the same cycle.

Verification (DATA_W=8, DIM=2, RD_LAT=1, ADDR_W=8)
REQ-031 SHALL cover add: RAM[0..3]=1,2,3,4, RAM[4..7]=10,20,30,40, base_c=8, op=00, start -> RAM[8..11]=11,22,33,44, done high exactly 21 cycles after the start edge, busy high for the 20 cycles before it.
REQ-032 SHALL cover saturation: A=100,B=50 with op=00 -> 127 (0x7F); A=-100,B=50 with op=01 -> -128 (0x80); A=-128 with op=11 -> 127.
REQ-033 SHALL cover transpose: RAM[0..3]=1,2,3,4, op=10, base_c=8 -> RAM[8..11]=1,3,2,4; mem_addr never in 4..7; done 13 cycles after start.
REQ-034 SHALL cover reset mid-operation: rst=0 on cycle 7 of the REQ-031 run -> next cycle busy=0, mem_we=0; RAM[8]=11, RAM[9..11] unchanged; no done pulse.
REQ-035 SHALL cover start handling: start pulsed while busy and during DONE -> ignored, only one done pulse; start in the next IDLE cycle -> new run begins.
REQ-036 SHALL cover address wrap: base_c=254, op=11 -> writes to addresses 254, 255, 0, 1 in that order.
